fft_frame_sequencer: RTL and testbench
======================================

Name: fft_frame_sequencer

Overview:
Frame-level scheduler in front of and behind the FFT/magnitude engine.
- Buffers slow-rate audio samples into a circular frame buffer.
- Bursts one contiguous frame into the FFT input stream.
- Waits for FFT completion, then sweeps the bin index across the magnitude engine.
- Forwards each (bin, magnitude) pair downstream under valid/ready backpressure.
- Sits between the audio sample FIFO and the peak-picking/fingerprint stage.

Parameters:
FFT_LENGTH, 1024, frame length (power of 2); also the buffer depth.
FFT_DW, 16, sample width.
MAG_W, 16, magnitude width.
NUM_BINS, FFT_LENGTH/2, bins swept per frame, 1..FFT_LENGTH.
FFT_N, $clog2(FFT_LENGTH), derived; not overridden.

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
enable  in  1  run frames while high; sampled in IDLE only
sample_valid  in  1  upstream sample present
sample_data  in  FFT_DW  signed audio sample
sample_ready  out  1  sample accepted when valid&&ready
fft_stream_active  out  1  FFT input strobe, one sample per cycle
fft_real  out  FFT_DW  FFT real input
fft_imag  out  FFT_DW  FFT imaginary input, always 0
fft_done  in  1  FFT done level from core
bin_index  out  11  bin address to magnitude engine, zero-extended from FFT_N bits
mag_ready  in  1  magnitude engine result pulse
magnitude  in  MAG_W  magnitude engine result
out_valid  out  1  result valid to downstream
out_bin  out  FFT_N  bin of result
out_mag  out  MAG_W  magnitude of result
out_last  out  1  high with last bin of frame
out_ready  in  1  downstream accept
frame_count  out  16  completed frames, wraps at 0xFFFF->0
busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, wr_ptr=0, fill count=0. Reset mid-frame aborts to IDLE and discards buffer contents.
- State IDLE: if enable, go to FILL with need=FFT_LENGTH.
- State FILL:
  - sample_ready=1.
  - Each handshake writes the buffer at wr_ptr, then wr_ptr++ (mod FFT_LENGTH) and need--.
  - When need reaches 0 (the accepting cycle), go to STREAM.
- State STREAM:
  - Reads FFT_LENGTH samples starting at wr_ptr (oldest first), with 1-cycle buffer read latency.
  - fft_stream_active is high for exactly FFT_LENGTH consecutive cycles, starting 2 cycles after STREAM entry; fft_real is registered alongside it.
  - sample_ready=0 in every state except FILL.
- State WAIT_FFT:
  - Waits for a rising edge of fft_done, using a registered previous value.
  - A level already high on entry is ignored.
- State SWEEP:
  - bin_index starts at 0; discard=1 on every bin_index change.
  - On mag_ready: if discard=1, clear discard only. The first result after an index change may belong to the previous index and is always dropped.
  - Otherwise capture out_mag=magnitude, out_bin=bin_index, out_valid=1, out_last=(bin_index==NUM_BINS-1), then go to OUTPUT.
  - mag_ready pulses arriving while in OUTPUT are ignored.
- State OUTPUT:
  - Hold out_* stable while out_valid&&!out_ready.
  - On handshake, clear out_valid and out_last.
  - If last: frame_count++, go to IDLE (or FILL if enable is still high).
  - Otherwise: bin_index++, discard=1, return to SWEEP.
- Fill amount without overlap: need=FFT_LENGTH every frame.
- Latency:
  - FILL exit to first fft_stream_active: 2 cycles.
  - Handshake to next bin_index update: 1 cycle.
- Simultaneous mag_ready and entry into SWEEP: treated as discard.
- enable dropping mid-frame has no effect until the frame completes.

Optional Feature:
FRAME_OVERLAP_EN:
- Defined: 50% overlap.
  - First frame after IDLE fills FFT_LENGTH samples.
  - Later frames, entered directly from OUTPUT, fill FFT_LENGTH/2 new samples.
  - STREAM still emits FFT_LENGTH samples from wr_ptr, so the older half is reused.
- Undefined: every frame fills FFT_LENGTH samples and no buffer data is reused.

Test Plan:
- Single frame, FFT_LENGTH=16, NUM_BINS=8, samples 1..16 -> fft_real 1..16 on 16 consecutive active cycles; fft_imag=0; sample_ready=0 after the 16th sample.
- SWEEP with model engine returning magnitude=bin*3 after 5 cycles, repeating per index -> out_bin 0..7 with out_mag 0,3,..,21; out_last only at bin 7; frame_count=1; the first pulse after each index change is dropped.
- Hold out_ready=0 for 10 cycles at bin 2 -> out_bin/out_mag stable, bin_index stays 2, extra mag_ready pulses ignored.
- fft_done already high when WAIT_FFT is entered -> no advance until fft_done falls and rises again.
- Reset asserted mid-STREAM at sample 7 -> next cycle all outputs 0, IDLE; a fresh frame of 16 samples is required.
- FRAME_OVERLAP_EN, enable held, samples 1..24 -> frame 1 streams 1..16; frame 2 accepts only 8 samples and streams 9..24.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: frame-level scheduler around the FFT and magnitude engines.
// It collects audio samples into a circular buffer and bursts one frame, oldest
// sample first, into the FFT. It then sweeps bin indices across the magnitude
// engine and forwards (bin, magnitude) pairs under valid/ready.
// Optional feature macro: FRAME_OVERLAP_EN. When it is defined, frames that follow
// directly on from a previous frame fill only FFT_LENGTH/2 new samples (50% overlap).
module fft_frame_sequencer #(
  parameter int unsigned  FFT_LENGTH = 1024,
  parameter int unsigned  FFT_DW     = 16,
  parameter int unsigned  MAG_W      = 16,
  parameter int unsigned  NUM_BINS   = FFT_LENGTH / 2,
  localparam int unsigned FFT_N      = $clog2(FFT_LENGTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [FFT_DW-1:0] sample_data,
  output logic              sample_ready,
  output logic              fft_stream_active,
  output logic [FFT_DW-1:0] fft_real,
  output logic [FFT_DW-1:0] fft_imag,
  input  logic              fft_done,
  output logic [10:0]       bin_index,
  input  logic              mag_ready,
  input  logic [MAG_W-1:0]  magnitude,
  output logic              out_valid,
  output logic [FFT_N-1:0]  out_bin,
  output logic [MAG_W-1:0]  out_mag,
  output logic              out_last,
  input  logic              out_ready,
  output logic [15:0]       frame_count,
  output logic              busy
);

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StStream,
    StWaitFft,
    StSweep,
    StOutput
  } state_e;

  localparam logic [FFT_N:0]   FullFill = (FFT_N + 1)'(FFT_LENGTH);
  localparam logic [FFT_N:0]   OneLeft  = (FFT_N + 1)'(1);
  localparam logic [FFT_N-1:0] LastIdx  = FFT_N'(FFT_LENGTH - 1);
  localparam logic [FFT_N-1:0] LastBin  = FFT_N'(NUM_BINS - 1);
`ifdef FRAME_OVERLAP_EN
  // Back-to-back frames reuse the older half of the buffer.
  localparam logic [FFT_N:0]   NextFill = (FFT_N + 1)'(FFT_LENGTH / 2);
`else
  localparam logic [FFT_N:0]   NextFill = FullFill;
`endif

  state_e            state_q, state_d;
  logic [FFT_N-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FFT_N:0]    need_q, need_d;
  logic [FFT_N-1:0]  rd_cnt_q, rd_cnt_d;
  logic [FFT_N-1:0]  bin_q, bin_d;
  logic              discard_q, discard_d;
  logic              out_valid_q, out_valid_d;
  logic [FFT_N-1:0]  out_bin_q, out_bin_d;
  logic [MAG_W-1:0]  out_mag_q, out_mag_d;
  logic              out_last_q, out_last_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              done_prev_q;
  logic              rd_vld_q;
  logic [FFT_DW-1:0] rd_data_q;
  logic              active_q;
  logic [FFT_DW-1:0] real_q;
  logic              wr_en;
  logic [FFT_N-1:0]  rd_addr;

  logic [FFT_DW-1:0] mem [FFT_LENGTH];

  // Oldest sample sits at wr_ptr, so the burst reads forward from there.
  assign rd_addr = wr_ptr_q + rd_cnt_q;

  // Next-state and datapath updates for the frame FSM.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    need_d        = need_q;
    rd_cnt_d      = rd_cnt_q;
    bin_d         = bin_q;
    discard_d     = discard_q;
    out_valid_d   = out_valid_q;
    out_bin_d     = out_bin_q;
    out_mag_d     = out_mag_q;
    out_last_d    = out_last_q;
    frame_count_d = frame_count_q;
    wr_en         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StFill;
          need_d  = FullFill;
        end
      end
      StFill: begin
        if (sample_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          need_d   = need_q - 1'b1;
          if (need_q == OneLeft) begin
            state_d  = StStream;
            rd_cnt_d = '0;
          end
        end
      end
      StStream: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == LastIdx) begin
          state_d = StWaitFft;
        end
      end
      StWaitFft: begin
        // Only a fresh rising edge counts; a level left high from before is ignored.
        if (fft_done && !done_prev_q) begin
          state_d   = StSweep;
          bin_d     = '0;
          discard_d = 1'b1;
        end
      end
      StSweep: begin
        if (mag_ready) begin
          if (discard_q) begin
            // First result after an index change may still be for the old index.
            discard_d = 1'b0;
          end else begin
            out_valid_d = 1'b1;
            out_bin_d   = bin_q;
            out_mag_d   = magnitude;
            out_last_d  = (bin_q == LastBin);
            state_d     = StOutput;
          end
        end
      end
      StOutput: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            frame_count_d = frame_count_q + 16'd1;
            bin_d         = '0;
            if (enable) begin
              state_d = StFill;
              need_d  = NextFill;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bin_d     = bin_q + 1'b1;
            discard_d = 1'b1;
            state_d   = StSweep;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      need_q        <= '0;
      rd_cnt_q      <= '0;
      bin_q         <= '0;
      discard_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_bin_q     <= '0;
      out_mag_q     <= '0;
      out_last_q    <= 1'b0;
      frame_count_q <= '0;
      done_prev_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      need_q        <= need_d;
      rd_cnt_q      <= rd_cnt_d;
      bin_q         <= bin_d;
      discard_q     <= discard_d;
      out_valid_q   <= out_valid_d;
      out_bin_q     <= out_bin_d;
      out_mag_q     <= out_mag_d;
      out_last_q    <= out_last_d;
      frame_count_q <= frame_count_d;
      done_prev_q   <= fft_done;
    end
  end

  // Frame buffer: write on accepted samples, synchronous one-cycle read.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_ptr_q] <= sample_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  // Stream pipeline: read-valid stage, then registered FFT strobe and data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q <= 1'b0;
      active_q <= 1'b0;
      real_q   <= '0;
    end else begin
      rd_vld_q <= (state_q == StStream);
      active_q <= rd_vld_q;
      real_q   <= rd_vld_q ? rd_data_q : '0;
    end
  end

  assign sample_ready      = (state_q == StFill);
  assign fft_stream_active = active_q;
  assign fft_real          = real_q;
  assign fft_imag          = '0;
  assign bin_index         = 11'(bin_q);
  assign out_valid         = out_valid_q;
  assign out_bin           = out_bin_q;
  assign out_mag           = out_mag_q;
  assign out_last          = out_last_q;
  assign frame_count       = frame_count_q;
  assign busy              = (state_q != StIdle);

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: directed frame sequence with randomized samples,
// handshake gaps and magnitudes. Expected FFT input is the most recent
// FFT_LENGTH accepted samples, kept in a history queue.
module tb_fft_frame_sequencer;

  localparam int L  = 16;
  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        sample_ready;
  logic        fft_stream_active;
  logic [15:0] fft_real;
  logic [15:0] fft_imag;
  logic        fft_done;
  logic [10:0] bin_index;
  logic        mag_ready = 1'b0;
  logic [15:0] magnitude = 16'h0;
  logic        out_valid;
  logic [3:0]  out_bin;
  logic [15:0] out_mag;
  logic        out_last;
  logic        out_ready;
  logic [15:0] frame_count;
  logic        busy;

  fft_frame_sequencer #(
    .FFT_LENGTH(L),
    .FFT_DW    (16),
    .MAG_W     (16),
    .NUM_BINS  (NB)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .sample_valid     (sample_valid),
    .sample_data      (sample_data),
    .sample_ready     (sample_ready),
    .fft_stream_active(fft_stream_active),
    .fft_real         (fft_real),
    .fft_imag         (fft_imag),
    .fft_done         (fft_done),
    .bin_index        (bin_index),
    .mag_ready        (mag_ready),
    .magnitude        (magnitude),
    .out_valid        (out_valid),
    .out_bin          (out_bin),
    .out_mag          (out_mag),
    .out_last         (out_last),
    .out_ready        (out_ready),
    .frame_count      (frame_count),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] hist [$];
  int          frames_exp = 0;
  bit          cont = 1'b0;
  int          det_next = 1;
  bit          aborted;

  // Magnitude engine model: a pulse every 6 cycles carrying the result for the
  // index seen 4 cycles earlier, so a pulse right after an index change is stale.
  logic [15:0] mag_tab [NB] = '{default: '0};
  logic [10:0] eng_pipe [5] = '{default: '0};
  int          eng_cnt = 0;
  bit          eng_bad = 1'b0;

  always @(negedge clk) begin
    for (int i = 4; i > 0; i--) eng_pipe[i] = eng_pipe[i-1];
    eng_pipe[0] = bin_index;
    eng_cnt     = (eng_cnt == 5) ? 0 : eng_cnt + 1;
    mag_ready   = (eng_cnt == 0);
    magnitude   = eng_bad ? ~mag_tab[eng_pipe[4][2:0]] : mag_tab[eng_pipe[4][2:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int fill_need();
    int n = L;
`ifdef FRAME_OVERLAP_EN
    if (cont) n = L / 2;
`endif
    return n;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_sample_ready"}, 32'(sample_ready), 32'(0));
    chk({tag, "_stream_active"}, 32'(fft_stream_active), 32'(0));
    chk({tag, "_fft_real"}, 32'(fft_real), 32'(0));
    chk({tag, "_fft_imag"}, 32'(fft_imag), 32'(0));
    chk({tag, "_bin_index"}, 32'(bin_index), 32'(0));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_out_bin"}, 32'(out_bin), 32'(0));
    chk({tag, "_out_mag"}, 32'(out_mag), 32'(0));
    chk({tag, "_out_last"}, 32'(out_last), 32'(0));
    chk({tag, "_frame_count"}, 32'(frame_count), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  // Offer samples with random gaps until the expected fill amount is accepted.
  task automatic fill(input bit det);
    int need = fill_need();
    int got  = 0;
    int t    = 0;
    while (got < need && t < 40 * L) begin
      sample_valid = ($urandom_range(0, 3) != 0);
      sample_data  = det ? 16'(det_next) : 16'($urandom);
      if (sample_valid && sample_ready) begin
        hist.push_back(sample_data);
        got++;
        if (det) det_next++;
      end
      tick();
      t++;
    end
    chk("fill_count", 32'(got), 32'(need));
    sample_valid = 1'b1;
    sample_data  = 16'hdead;
    chk("ready_low_after_fill", 32'(sample_ready), 32'(0));
  endtask

  // Check the FFT burst cycle by cycle; optionally reset at a given sample.
  task automatic stream(input int reset_at, output bit ab);
    logic [15:0] win [L];
    int base = hist.size() - L;
    for (int i = 0; i < L; i++) win[i] = (base >= 0) ? hist[base + i] : 16'h0;
    ab = 1'b0;
    for (int j = 0; j < L + 4; j++) begin
      bit exp_act = (j >= 2) && (j < L + 2);
      chk("stream_active", 32'(fft_stream_active), 32'(exp_act));
      if (exp_act) chk("fft_real", 32'(fft_real), 32'(win[j-2]));
      chk("fft_imag", 32'(fft_imag), 32'(0));
      chk("ready_in_stream", 32'(sample_ready), 32'(0));
      sample_data = 16'($urandom);
      if (exp_act && (j - 2) == reset_at) begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        tick();
        chk_zero("reset_mid");
        reset = 1'b0;
        hist.delete();
        frames_exp = 0;
        cont       = 1'b0;
        ab         = 1'b1;
        break;
      end
      tick();
    end
    sample_valid = 1'b0;
  endtask

  // Produce the FFT done edge; with stale=1 the level is already high on entry.
  task automatic fft_finish(input bit stale);
    if (stale) begin
      for (int i = 0; i < 20; i++) begin
        chk("no_sweep_on_stale_done", 32'(out_valid), 32'(0));
        tick();
      end
      fft_done = 1'b0;
      tick();
      tick();
    end else begin
      repeat ($urandom_range(0, 3)) tick();
    end
    fft_done = 1'b1;
    tick();
    tick();
    tick();
    fft_done = 1'b0;
  endtask

  // Collect every bin with random backpressure; long stall on stall_bin.
  task automatic sweep(input int stall_bin, input bit end_en);
    for (int b = 0; b < NB; b++) begin
      int t = 0;
      int stall;
      while (!out_valid && t < 200) begin
        tick();
        t++;
      end
      chk("out_valid_seen", 32'(out_valid), 32'(1));
      chk("out_bin", 32'(out_bin), 32'(b));
      chk("out_mag", 32'(out_mag), 32'(mag_tab[b]));
      chk("out_last", 32'(out_last), 32'(b == NB - 1));
      chk("bin_index", 32'(bin_index), 32'(b));
      stall = (b == stall_bin) ? 10 : $urandom_range(0, 2);
      if (b == stall_bin) eng_bad = 1'b1;
      for (int s = 0; s < stall; s++) begin
        tick();
        chk("hold_valid", 32'(out_valid), 32'(1));
        chk("hold_bin", 32'(out_bin), 32'(b));
        chk("hold_mag", 32'(out_mag), 32'(mag_tab[b]));
        chk("hold_bin_index", 32'(bin_index), 32'(b));
      end
      eng_bad = 1'b0;
      if (b == 0) enable = end_en;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("valid_clear", 32'(out_valid), 32'(0));
      if (b < NB - 1) begin
        chk("bin_index_step", 32'(bin_index), 32'(b + 1));
      end else begin
        frames_exp++;
        chk("frame_count", 32'(frame_count), 32'(frames_exp));
        chk("busy_after_frame", 32'(busy), 32'(end_en));
        chk("last_clear", 32'(out_last), 32'(0));
      end
    end
    cont = end_en;
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample_data  = 16'h0;
    fft_done     = 1'b0;
    out_ready    = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();
    chk("idle_not_busy", 32'(busy), 32'(0));

    // Frame A: samples 1..16, magnitude = 3*bin, enable held for the next frame.
    for (int b = 0; b < NB; b++) mag_tab[b] = 16'(3 * b);
    enable = 1'b1;
    fill(1'b1);
    stream(-1, aborted);
    fft_finish(1'b0);
    sweep(-1, 1'b1);

    // Frame B: continues counting samples, stale fft_done, long stall at bin 2.
    for (int b = 0; b < NB; b++) mag_tab[b] = 16'($urandom);
    fft_done = 1'b1;
    fill(1'b1);
    stream(-1, aborted);
    fft_finish(1'b1);
    sweep(2, 1'b0);

    // Frame C: started from idle with random data.
    for (int b = 0; b < NB; b++) mag_tab[b] = 16'($urandom);
    enable = 1'b1;
    fill(1'b0);
    stream(-1, aborted);
    fft_finish(1'b0);
    sweep(-1, 1'b1);

    // Frame D: reset lands on the 7th streamed sample.
    fill(1'b0);
    stream(6, aborted);

    // Frame E: fresh full frame after the reset.
    for (int b = 0; b < NB; b++) mag_tab[b] = 16'($urandom);
    fill(1'b0);
    stream(-1, aborted);
    fft_finish(1'b0);
    sweep(-1, 1'b0);
    repeat (3) tick();
    chk("idle_at_end", 32'(busy), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
